// File: rtl/mult_seq_if.sv
// Operand/product handshake bundle for the sequential signed multiplier.
// The master drives operands and out_ready. The slave is the multiplier, which returns
// in_ready, out_valid and the product.
interface mult_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   a;
    logic signed [WIDTH-1:0]   b;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [2*WIDTH-1:0] product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/mult_seq.sv
// Sequential signed multiplier. It uses radix-2 shift-add on operand magnitudes and adds
// one partial product per cycle.
// The sign is re-applied with a full-width two's complement negation, so a zero result
// stays +0.
// Optional macro MULT_EARLY_TERM_EN: CALC ends as soon as the remaining multiplier bits
// are all zero, and a final alignment shift then gives the correct product.
module mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    mult_seq_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             sign_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [PW-1:0]    product_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   upper_sum;
    logic [PW-1:0]    acc_step;
    logic [WIDTH-1:0] mplier_step;
    logic             last_step;
    logic [PW-1:0]    result_mag;
    logic [PW-1:0]    product_d;

    // Operand magnitudes; -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is still correct unsigned
    always_comb begin
        a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
        b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;
    end

    // One shift-add step, with the carry out of the upper half shifted back in
    always_comb begin
        upper_sum   = {1'b0, acc_q[PW-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_step    = {upper_sum, acc_q[WIDTH-1:1]};
        mplier_step = mplier_q >> 1;
`ifdef MULT_EARLY_TERM_EN
        last_step   = (cnt_q == CW'(WIDTH - 1)) || (mplier_step == '0);
        // Apply the right shifts that the skipped steps would have performed
        result_mag  = acc_step >> (CW'(WIDTH - 1) - cnt_q);
`else
        last_step   = (cnt_q == CW'(WIDTH - 1));
        result_mag  = acc_step;
`endif
        product_d   = sign_q ? -result_mag : result_mag;
    end

    // Control FSM with registered handshake outputs and product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid && in_ready_q) begin
                        mcand_q    <= a_mag;
                        mplier_q   <= b_mag;
                        sign_q     <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q    <= acc_step;
                    mplier_q <= mplier_step;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_step) begin
                        product_q   <= product_d;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
endmodule

// File: tb/tb_mult_seq.sv
// Directed and random bench for mult_seq with WIDTH = 8. It also handles the
// MULT_EARLY_TERM_EN build.
module tb_mult_seq;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   cyc;
    int   hs_cnt;

    mult_seq_if #(.WIDTH(8)) bus ();

    mult_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected cycles from accept to out_valid
    function automatic int exp_lat(input int bv);
`ifdef MULT_EARLY_TERM_EN
        int m;
        int n;
        m = (bv < 0) ? -bv : bv;
        n = 1;
        for (int i = 0; i < 8; i++) if (m[i]) n = i + 1;
        return n;
`else
        return 8 + (bv - bv);
`endif
    endfunction

    // Present operands and return at #1 after the accepting edge
    task automatic send(input int av, input int bv, output int acc_cyc);
        int w;
        bus.a = 8'(av);
        bus.b = 8'(bv);
        w = 0;
        while (!bus.in_ready && w < 30) begin
            tick();
            w++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required=1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        tick();
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid is observed (bounded)
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %0b required 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.product !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_product: got %h required 0000", bus.product);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b required 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        int t0;
        int lat;
        bus.out_ready = 1'b1;
        send(5, 10, t0);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: in_ready got %0b required 0", bus.in_ready);
        end
        wait_valid(lat);
        n_cmp++;
        if (lat !== exp_lat(10)) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d required %0d", lat, exp_lat(10));
        end
        n_cmp++;
        if (bus.product !== 16'h0032) begin
            n_fail++;
            $display("FAIL basic_product: got %h required 0032", bus.product);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_release: out_valid=%0b in_ready=%0b required 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_signs();
        int av[6]         = '{-128, -128, -1, 0, 37, 7};
        int bv[6]         = '{-128, 127, 1, -77, 0, -1};
        logic [15:0] e[6] = '{16'h4000, 16'hC080, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFF9};
        int t0;
        int lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(av[i], bv[i], t0);
            wait_valid(lat);
            n_cmp++;
            if (lat !== exp_lat(bv[i])) begin
                n_fail++;
                $display("FAIL signs_latency[%0d]: got %0d required %0d", i, lat, exp_lat(bv[i]));
            end
            n_cmp++;
            if (bus.product !== e[i]) begin
                n_fail++;
                $display("FAIL signs_product[%0d]: got %h required %h", i, bus.product, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int t0;
        int lat;
        bus.out_ready = 1'b0;
        send(12, -3, t0);
        wait_valid(lat);
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 8'd99;
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.product !== 16'hFFDC || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%0b product=%h ready=%0b required 1/ffdc/0",
                         i, bus.out_valid, bus.product, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_accept: out_valid got %0b required 0", bus.out_valid);
        end
        // The ignored a=99 pulses must not have started a transaction
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.product !== 16'hFFDC) begin
            n_fail++;
            $display("FAIL stall_ignored: in_ready=%0b product=%h required 1/ffdc",
                     bus.in_ready, bus.product);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        int lat;
        bus.out_ready = 1'b1;
        send(100, 100, t0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.product !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_clear: valid=%0b product=%h required 0/0000",
                     bus.out_valid, bus.product);
        end
        tick();
        rst_n = 1'b1;
        repeat (12) begin
            tick();
            if (bus.out_valid !== 1'b0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL midreset_emit: out_valid got %0b required 0", bus.out_valid);
            end
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.product !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_idle: in_ready=%0b product=%h required 1/0000",
                     bus.in_ready, bus.product);
        end
        send(2, 3, t0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== exp_lat(3) || bus.product !== 16'h0006) begin
            n_fail++;
            $display("FAIL midreset_next: lat=%0d product=%h required %0d/0006",
                     lat, bus.product, exp_lat(3));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        int lat;
        bus.out_ready = 1'b1;
        send(3, 4, t0);
        wait_valid(lat);
        tick();
        send(-5, 6, t1);
        n_cmp++;
        if (t1 - t0 !== exp_lat(4) + 2) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d required %0d", t1 - t0, exp_lat(4) + 2);
        end
        wait_valid(lat);
        n_cmp++;
        if (bus.product !== 16'hFFE2) begin
            n_fail++;
            $display("FAIL b2b_product: got %h required ffe2", bus.product);
        end
        tick();
    endtask

    task automatic test_random();
        int ai;
        int bi;
        int t0;
        int lat;
        int base;
        logic [15:0] e;
        base = hs_cnt;
        for (int n = 0; n < 1000; n++) begin
            ai = int'($urandom_range(0, 255)) - 128;
            bi = int'($urandom_range(0, 255)) - 128;
            e  = 16'(ai * bi);
            bus.out_ready = 1'b0;
            send(ai, bi, t0);
            wait_valid(lat);
            n_cmp++;
            if (lat !== exp_lat(bi)) begin
                n_fail++;
                $display("FAIL rand_latency[%0d]: got %0d required %0d", n, lat, exp_lat(bi));
            end
            repeat ($urandom_range(0, 3)) tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.product !== e) begin
                n_fail++;
                $display("FAIL rand_product[%0d] %0d*%0d: valid=%0b got %h required %h",
                         n, ai, bi, bus.out_valid, bus.product, e);
            end
            bus.out_ready = 1'b1;
            tick();
        end
        n_cmp++;
        if (hs_cnt - base !== 1000) begin
            n_fail++;
            $display("FAIL rand_handshakes: got %0d required 1000", hs_cnt - base);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        hs_cnt = 0;
        test_reset();
        test_basic();
        test_signs();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
